// File: rtl/ysyx_24100027_fetch_seq.sv
// ysyx_24100027_fetch_seq
// Multi-cycle fetch/commit sequencer for the single-cycle RV32 core.
// Owns the architectural PC, fetches one instruction at a time over a
// valid/ready port, presents it to the core for one EXEC cycle and then
// retires it. The commit pulse gates the core's register-file write.
//
// Optional feature macro: YSYX_24100027_FETCH_TIMEOUT_EN
//   When defined, a WAIT-state counter raises err after TIMEOUT_CYCLES
//   cycles without ifu_rvalid. When undefined, WAIT stalls indefinitely.

module ysyx_24100027_fetch_seq #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    output logic [31:0] ifu_addr,
    input  logic        ifu_ready,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    input  logic [31:0] npc,
    output logic        commit,
    output logic        halted,
    output logic        err,
    output logic [31:0] instret
);

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // The WAIT counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 32'd1 || TIMEOUT_CYCLES > 32'd65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    function automatic logic is_ebreak(input logic [31:0] word);
        return (word == INST_EBREAK);
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        halted_r;
    logic        err_r;
    logic [31:0] instret_r;

    logic        commit_s;
    logic        pc_load_s;
    logic        inst_load_s;
    logic        set_halt_s;
    logic        set_err_s;
    logic        timeout_s;

`ifdef YSYX_24100027_FETCH_TIMEOUT_EN
    logic [15:0] wait_cnt_r;

    // WAIT-cycle counter: held at zero outside WAIT, so it starts from zero on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 16'd0;
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= 16'd0;
        end else if (!ifu_rvalid) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The limit is reached when this WAIT cycle would bring the count to TIMEOUT_CYCLES.
    assign timeout_s = (state_r == ST_WAIT) &&
                       (({16'd0, wait_cnt_r} + 32'd1) == TIMEOUT_CYCLES);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and per-state control; rvalid beats the timeout in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        pc_load_s   = 1'b0;
        inst_load_s = 1'b0;
        set_halt_s  = 1'b0;
        set_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
                if (ifu_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (ifu_rvalid) begin
                    inst_load_s = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else if (timeout_s) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_EXEC: begin
                if (is_ebreak(inst_r)) begin
                    commit_s    = 1'b1;
                    set_halt_s  = 1'b1;
                    state_nxt_s = ST_HALT;
                end else if (is_misaligned(npc)) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    commit_s    = 1'b1;
                    pc_load_s   = 1'b1;
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                // Unused encodings are treated as a fault.
                set_err_s   = 1'b1;
                state_nxt_s = ST_ERR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC and instruction latches: pc moves only on leaving EXEC, inst only on leaving WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r   <= RESET_PC;
            inst_r <= INST_NOP;
        end else begin
            if (pc_load_s) begin
                pc_r <= npc;
            end else begin
                pc_r <= pc_r;
            end
            if (inst_load_s) begin
                inst_r <= ifu_rdata;
            end else begin
                inst_r <= inst_r;
            end
        end
    end

    // Sticky status flags and the wrapping retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_r  <= 1'b0;
            err_r     <= 1'b0;
            instret_r <= 32'd0;
        end else begin
            halted_r  <= halted_r | set_halt_s;
            err_r     <= err_r | set_err_s;
            if (commit_s) begin
                instret_r <= instret_r + 32'd1;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign ifu_req  = (state_r == ST_REQ);
    assign ifu_addr = pc_r;
    assign pc       = pc_r;
    assign inst     = inst_r;
    assign commit   = commit_s;
    assign halted   = halted_r;
    assign err      = err_r;
    assign instret  = instret_r;

endmodule

// File: doc/ysyx_24100027_fetch_seq.md
# ysyx_24100027_fetch_seq

Multi-cycle fetch/commit sequencer for the single-cycle RV32 core datapath. It owns the architectural PC and fetches each instruction over a valid/ready memory port. It presents the latched instruction and PC to the core for exactly one execute cycle, then commits the core's `npc`. Its `commit` pulse gates the core's register-file write enable, so the GPR file updates once per instruction, not once per clock.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.
- `TIMEOUT_CYCLES`, 255, maximum WAIT cycles before error; used only with the timeout macro.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ifu_req`  out  1  fetch request valid.
- `ifu_addr`  out  32  fetch address, equals `pc` whenever `ifu_req`=1.
- `ifu_ready`  in  1  memory accepts the request this cycle.
- `ifu_rvalid`  in  1  fetch data valid.
- `ifu_rdata`  in  32  fetched instruction word.
- `pc`  out  32  architectural PC to the core.
- `inst`  out  32  latched instruction to the core.
- `npc`  in  32  next PC computed combinationally by the core.
- `commit`  out  1  one-cycle retire pulse; the core ANDs it into `regwr`.
- `halted`  out  1  sticky; ebreak retired.
- `err`  out  1  sticky; misaligned `npc`, or fetch timeout.
- `instret`  out  32  retired-instruction count, wraps at 2^32.

## Operation
The sequencer is a six-state FSM: IDLE, REQ, WAIT, EXEC, HALT, ERR.
- IDLE: the state entered at reset. Unconditionally moves to REQ on the next clock.
- REQ:
  - Drives `ifu_req`=1 and `ifu_addr`=`pc`. Both are held stable until `ifu_ready`=1.
  - On `ifu_ready`=1, moves to WAIT.
  - `ifu_rvalid` is ignored while in REQ.
- WAIT:
  - `ifu_req`=0.
  - On `ifu_rvalid`=1, latches `inst`<=`ifu_rdata` and moves to EXEC.
- EXEC: the single execute cycle; `inst` and `pc` are stable. Checks apply in this priority order:
  1. `inst`==32'h0010_0073 (ebreak): `commit`=1, `instret`+=1, `pc` unchanged, `halted`<=1, next state HALT.
  2. `npc[1:0]`!=0: `commit`=0, `pc` unchanged, `err`<=1, next state ERR.
  3. Otherwise: `commit`=1, `pc`<=`npc`, `instret`+=1, next state REQ.
- HALT and ERR:
  - Both are absorbing until `rst` is asserted.
  - In both, `ifu_req`=0 and `commit`=0.
  - All `ifu_*` inputs are ignored.
- `commit` is combinational from (state==EXEC and the EXEC checks), and is never asserted outside EXEC.
- `instret` is a 32-bit unsigned counter; 32'hFFFF_FFFF+1 wraps to 0.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `inst`=32'h0000_0013 (nop), `ifu_req`=0, `commit`=0, `halted`=0, `err`=0, `instret`=0.
- Minimum per-instruction latency is 4 cycles (IDLE only once after reset; steady state 3 cycles: REQ, WAIT, EXEC). This occurs when `ifu_ready`=1 in the first REQ cycle and `ifu_rvalid`=1 in the first WAIT cycle.
- Throughput: at most one commit per 3 cycles; no overlap of fetches.
- Handshake rules:
  - One outstanding request at most.
  - Memory must not raise `ifu_rvalid` earlier than the cycle after acceptance.
  - A request, once raised, is never withdrawn except by reset.
- Reset mid-transaction (REQ or WAIT):
  - The fetch is abandoned and the FSM returns to IDLE.
  - A stale `ifu_rvalid` arriving after reset deassertion is ignored, because it lands in IDLE or REQ.
  - The memory side must drop stale responses.
- `pc` and `inst` change only at the clock edge that leaves EXEC or WAIT respectively.
- The core's combinational path sees stable operands for the whole EXEC cycle.

## Configuration
- Macro: `YSYX_24100027_FETCH_TIMEOUT_EN`.
- With the macro defined:
  - An 8..16-bit WAIT counter is cleared on entry to WAIT and increments each WAIT cycle without `ifu_rvalid`.
  - When the counter reaches `TIMEOUT_CYCLES`, the next state is ERR and `err`<=1.
  - `ifu_rvalid` in the same cycle as the limit wins, so the fetch completes normally.
- Without the macro: WAIT stalls indefinitely, the counter is not synthesized, `TIMEOUT_CYCLES` is unused, and `err` is set only by a misaligned `npc`.

## Test plan
- Release `rst`; memory returns `ifu_ready`=1 immediately and `ifu_rvalid` one cycle after acceptance; three addi words at 0x8000_0000, 0x8000_0004, 0x8000_0008 -> `ifu_addr` sequence 0x8000_0000/04/08, `commit` pulses every 3 cycles, `instret`=3.
- Hold `ifu_ready`=0 for 5 cycles in REQ -> `ifu_req`=1 and `ifu_addr` stable throughout; no `commit`; one commit after acceptance.
- Fetch 32'h0010_0073 -> one `commit` pulse, `halted`=1, `pc` frozen, `ifu_req`=0 forever; further `ifu_rvalid` pulses are ignored.
- Core drives `npc`=0x8000_0002 -> `commit`=0, `err`=1, `instret` unchanged, FSM in ERR.
- Assert `rst` in WAIT, then return `ifu_rvalid` after release -> `inst`=0x0000_0013, `pc`=`RESET_PC`, no commit from the stale data.
- With `YSYX_24100027_FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, withhold `ifu_rvalid` -> `err`=1 after 4 WAIT cycles; without the macro -> still in WAIT after 1000 cycles, `err`=0.
